// File: rtl/burst_tone_pkg.sv
// Shared types and constants for the burst tone generator: FSM state encoding,
// LFSR seed/taps for the optional noise, and a signed saturation helper.
package burst_tone_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    FINISH
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int saturate(input int value, input int width);
    int hi;
    int lo;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/burst_tone_generator_if.sv
// Control and sample-stream bundle of the burst tone generator; the generator
// uses the slave modport, the controlling/consuming side uses master.
interface burst_tone_generator_if #(
  parameter int SAMPLE_DATA_WIDTH = 8
);
  logic                                start;
  logic [7:0]                          num_bursts;
  logic                                abort;
  logic                                busy;
  logic                                done;
  logic                                axiov;
  logic signed [SAMPLE_DATA_WIDTH-1:0] axiod;

  modport master (
    output start, num_bursts, abort,
    input  busy, done, axiov, axiod
  );

  modport slave (
    input  start, num_bursts, abort,
    output busy, done, axiov, axiod
  );
endinterface

// File: rtl/sample_strobe_gen.sv
// Free-running sample-rate divider: strobe is high during the last clk of each
// CLKS_PER_SAMPLE-cycle sample period while enabled.
module sample_strobe_gen #(
  parameter int CLKS_PER_SAMPLE = 2272
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic strobe
);
  localparam int CW = $clog2(CLKS_PER_SAMPLE);

  logic [CW-1:0] count_q;

  assign strobe = enable && (count_q == CW'(CLKS_PER_SAMPLE - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= strobe ? '0 : count_q + CW'(1);
    end
  end
endmodule

// File: rtl/burst_tone_generator.sv
// Burst tone generator: square-wave bursts separated by silent gaps, one sample
// per strobe. Define BURST_TONE_NOISE_EN to add LFSR dither (-2..+1) to every sample.
module burst_tone_generator
  import burst_tone_pkg::*;
#(
  parameter int SAMPLE_DATA_WIDTH   = 8,
  parameter int CLKS_PER_SAMPLE     = 2272,
  parameter int HALF_PERIOD_SAMPLES = 10,
  parameter int ON_SAMPLES          = 2000,
  parameter int OFF_SAMPLES         = 2000,
  parameter int AMPLITUDE           = 100
) (
  input logic                  clk,
  input logic                  rst,
  burst_tone_generator_if.slave bus
);
  localparam int W  = SAMPLE_DATA_WIDTH;
  localparam int SW = $clog2(((ON_SAMPLES > OFF_SAMPLES) ? ON_SAMPLES : OFF_SAMPLES) + 1);
  localparam int HW = $clog2(HALF_PERIOD_SAMPLES + 1);

  state_t        state_q, state_d;
  logic          strobe;
  logic          run_enable;
  logic          accept;
  logic          clear_strobe;
  logic          emit;
  logic          last_on;
  logic          last_off;
  logic [7:0]    remaining_q;
  logic [SW-1:0] sample_cnt_q;
  logic [HW-1:0] half_cnt_q;
  logic          phase_neg_q;

  logic signed [W:0]   amp_ext;
  logic signed [W:0]   target;
  logic signed [W:0]   raw;
  logic signed [W-1:0] sample;

  assign run_enable = (state_q == ON) || (state_q == OFF);
  assign accept     = (state_q == IDLE) && bus.start;

  sample_strobe_gen #(
    .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
  ) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_strobe),
    .enable (run_enable),
    .strobe (strobe)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    clear_strobe = 1'b0;
    emit         = 1'b0;
    last_on      = 1'b0;
    last_off     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_bursts != 8'd0) begin
            state_d      = ON;
            clear_strobe = 1'b1;
          end else begin
            state_d = FINISH;
          end
        end
      end
      ON: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (strobe) begin
          emit = 1'b1;
          if (sample_cnt_q == SW'(ON_SAMPLES - 1)) begin
            last_on = 1'b1;
            state_d = OFF;
          end
        end
      end
      OFF: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (strobe) begin
          emit = 1'b1;
          if (sample_cnt_q == SW'(OFF_SAMPLES - 1)) begin
            last_off = 1'b1;
            state_d  = (remaining_q == 8'd1) ? FINISH : ON;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BURST_TONE_NOISE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      lfsr_q <= LFSR_SEED;
    end else if (emit) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_comb begin
    raw = target + $signed({{(W-1){1'b0}}, lfsr_q[1:0]}) - $signed((W+1)'(2));
  end
`else
  always_comb begin
    raw = target;
  end
`endif

  always_comb begin
    amp_ext = (W+1)'(AMPLITUDE);
    target  = '0;
    if (state_q == ON) begin
      target = phase_neg_q ? -amp_ext : amp_ext;
    end
    sample = W'(saturate(int'(raw), W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.axiov <= 1'b0;
      bus.axiod <= '0;
    end else begin
      state_q   <= state_d;
      bus.busy  <= (state_d == ON) || (state_d == OFF);
      bus.done  <= (state_d == FINISH);
      bus.axiov <= emit;
      if (emit) begin
        bus.axiod <= sample;
      end else if (state_d == IDLE) begin
        bus.axiod <= '0;
      end
    end
  end

  // Burst bookkeeping; phase restarts positive at the start of every burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q  <= '0;
      sample_cnt_q <= '0;
      half_cnt_q   <= '0;
      phase_neg_q  <= 1'b0;
    end else if (accept) begin
      remaining_q  <= bus.num_bursts;
      sample_cnt_q <= '0;
      half_cnt_q   <= '0;
      phase_neg_q  <= 1'b0;
    end else if (emit) begin
      sample_cnt_q <= (last_on || last_off) ? '0 : sample_cnt_q + SW'(1);
      if (last_off) begin
        remaining_q <= remaining_q - 8'd1;
        half_cnt_q  <= '0;
        phase_neg_q <= 1'b0;
      end else if (state_q == ON) begin
        if (half_cnt_q == HW'(HALF_PERIOD_SAMPLES - 1)) begin
          half_cnt_q  <= '0;
          phase_neg_q <= ~phase_neg_q;
        end else begin
          half_cnt_q <= half_cnt_q + HW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_burst_tone_generator.sv
// Scoreboard bench for burst_tone_generator with a short-period configuration;
// expected samples are queued at start and consumed on every axiov.
module tb_burst_tone_generator;
  localparam int W   = 8;
  localparam int CPS = 4;
  localparam int HP  = 2;
  localparam int ONS = 8;
  localparam int OFS = 4;
  localparam int AMP = 100;
  localparam int PER_BURST = ONS + OFS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  burst_tone_generator_if #(.SAMPLE_DATA_WIDTH(W)) bus ();

  burst_tone_generator #(
    .SAMPLE_DATA_WIDTH   (W),
    .CLKS_PER_SAMPLE     (CPS),
    .HALF_PERIOD_SAMPLES (HP),
    .ON_SAMPLES          (ONS),
    .OFF_SAMPLES         (OFS),
    .AMPLITUDE           (AMP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int sb[$];
  int rec[$];
  int axiov_cnt = 0;
  int done_cnt  = 0;
  int busy_cnt  = 0;
  int ncyc      = 0;
  int last_v    = -1;
  int last_run  = -1;
  int run_id    = 0;

  task automatic check(input string tag, input int observed, input int expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Sampling on the falling edge keeps the monitor clear of the active edge.
  always @(negedge clk) begin
    int e;
    ncyc++;
    if (bus.busy) busy_cnt++;
    if (bus.axiov) begin
      axiov_cnt++;
      if (last_v >= 0 && last_run == run_id) check("strobe_spacing", ncyc - last_v, CPS);
      last_v   = ncyc;
      last_run = run_id;
      rec.push_back(int'(bus.axiod));
      if (sb.size() == 0) begin
        check("unexpected_axiov", 1, 0);
      end else begin
        e = sb.pop_front();
`ifdef BURST_TONE_NOISE_EN
        check("noise_in_range", int'(int'(bus.axiod) >= e - 2 && int'(bus.axiod) <= e + 1), 1);
`else
        check("sample", int'(bus.axiod), e);
`endif
      end
    end
    if (bus.done) begin
      done_cnt++;
      check("busy_low_at_done", int'(bus.busy), 0);
      check("sb_empty_at_done", sb.size(), 0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_expected(input int n);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < ONS; i++) sb.push_back((((i / HP) % 2) == 0) ? AMP : -AMP);
      for (int i = 0; i < OFS; i++) sb.push_back(0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  int'(bus.busy), 0);
    check({tag, "_done"},  int'(bus.done), 0);
    check({tag, "_axiov"}, int'(bus.axiov), 0);
    check({tag, "_axiod"}, int'(bus.axiod), 0);
  endtask

  // Pulses start for one edge and checks the latency to the first sample.
  task automatic start_run(input int n);
    int base;
    int lat;
    tick();
    run_id++;
    base = axiov_cnt;
    bus.num_bursts = 8'(n);
    bus.start = 1'b1;
    push_expected(n);
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (axiov_cnt == base && lat < 50) begin
      tick();
      lat++;
    end
    check("first_latency", lat, CPS + 1);
  endtask

  task automatic wait_done(input int base, input int budget);
    int c;
    c = 0;
    while (done_cnt == base && c < budget) begin
      tick();
      c++;
    end
    if (done_cnt == base) check("done_timeout", 0, 1);
  endtask

  task automatic wait_axiov(input int target, input int budget);
    int c;
    c = 0;
    while (axiov_cnt < target && c < budget) begin
      tick();
      c++;
    end
    if (axiov_cnt < target) check("axiov_timeout", axiov_cnt, target);
  endtask

  task automatic run_full(input int n);
    int a0;
    int d0;
    a0 = axiov_cnt;
    d0 = done_cnt;
    start_run(n);
    wait_done(d0, 100 * PER_BURST * CPS);
    tick();
    check("run_strobes", axiov_cnt - a0, PER_BURST * n);
    check("run_done_count", done_cnt - d0, 1);
    check("idle_axiod_after_run", int'(bus.axiod), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int d0;
    int b0;
    bus.start = 1'b0;
    bus.num_bursts = 8'd0;
    bus.abort = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_idle_outputs("reset");
    end

    run_full(1);

    // Zero bursts: immediate done, never busy, no samples.
    a0 = axiov_cnt;
    d0 = done_cnt;
    b0 = busy_cnt;
    tick();
    bus.num_bursts = 8'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zero_done_pulse", int'(bus.done), 1);
    check("zero_busy", int'(bus.busy), 0);
    repeat (10) tick();
    check("zero_no_axiov", axiov_cnt - a0, 0);
    check("zero_done_count", done_cnt - d0, 1);
    check("zero_never_busy", busy_cnt - b0, 0);

    // Three bursts with a start re-pulse mid-run that must be ignored.
    a0 = axiov_cnt;
    d0 = done_cnt;
    start_run(3);
    repeat (20) tick();
    bus.num_bursts = 8'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(d0, 2000);
    repeat (12) tick();
    check("multi_strobes", axiov_cnt - a0, 3 * PER_BURST);
    check("multi_done_count", done_cnt - d0, 1);

    // Abort coincident with the 5th ON strobe.
    a0 = axiov_cnt;
    d0 = done_cnt;
    start_run(1);
    wait_axiov(a0 + 4, 200);
    repeat (3) tick();
    bus.abort = 1'b1;
    sb.delete();
    tick();
    bus.abort = 1'b0;
    check_idle_outputs("after_abort");
    repeat (20) tick();
    check("abort_strobes", axiov_cnt - a0, 4);
    check("abort_no_done", done_cnt - d0, 0);

    // Reset in the middle of the silent gap.
    a0 = axiov_cnt;
    d0 = done_cnt;
    start_run(1);
    wait_axiov(a0 + 10, 200);
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    check_idle_outputs("after_rst");
    repeat (20) tick();
    check("rst_strobes", axiov_cnt - a0, 10);
    check("rst_no_done", done_cnt - d0, 0);

    run_full(1);
`ifdef BURST_TONE_NOISE_EN
    run_full(1);
    for (int i = 0; i < PER_BURST; i++)
      check("noise_repeatable", rec[rec.size() - PER_BURST + i], rec[rec.size() - 2 * PER_BURST + i]);
`endif

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/burst_tone_generator.md
Name: burst_tone_generator

Overview:
- Stimulus source for the sample pipeline: emits a valid-qualified stream of signed samples at a fixed sample rate.
- The stream is a sequence of tone bursts, each a square wave of fixed amplitude, separated by silent gaps.
- Every burst-to-gap transition is a sharp amplitude drop that the envelope/minmax trigger path downstream must detect.
- Used for on-FPGA loopback self-test of the detector chain and for bench stimulus.

Parameters:
- SAMPLE_DATA_WIDTH, 8, width of signed output samples.
- CLKS_PER_SAMPLE, 2272, clk cycles between sample strobes (≥2).
- HALF_PERIOD_SAMPLES, 10, samples per tone half-cycle (≥1).
- ON_SAMPLES, 2000, samples per burst (≥1).
- OFF_SAMPLES, 2000, samples per silent gap (≥1).
- AMPLITUDE, 100, tone magnitude (1 .. 2^(SAMPLE_DATA_WIDTH-1)-1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a run; sampled only while busy=0.
- num_bursts  in  8  bursts in the run; latched when start is accepted.
- abort  in  1  terminate the current run.
- busy  out  1  a run is in progress.
- done  out  1  one-cycle pulse when a run completes normally.
- axiov  out  1  sample valid strobe, one cycle wide.
- axiod  out  SAMPLE_DATA_WIDTH (signed)  sample data; valid when axiov=1.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, axiov=0, axiod=0, FSM=IDLE, all counters=0. Reset mid-run abandons the run with no done pulse.
- FSM states: IDLE, ON, OFF, FINISH.
- IDLE:
  - start=1 with num_bursts≥1: latch num_bursts, clear the strobe counter, phase=positive, go to ON; busy=1 from the next cycle.
  - start=1 with num_bursts=0: go to FINISH. No samples are emitted.
- Strobe counter: counts 0..CLKS_PER_SAMPLE-1 while in ON/OFF. At terminal count, axiov=1 in the following cycle, together with the new axiod.
  - First sample: if start is sampled at edge k, axiov is high in the cycle after edge k+CLKS_PER_SAMPLE.
- ON:
  - Each strobe emits +AMPLITUDE when phase is positive, −AMPLITUDE when negative.
  - Phase toggles after every HALF_PERIOD_SAMPLES emitted samples.
  - After ON_SAMPLES samples, go to OFF.
  - Phase and half-period counter reset to positive/0 at the start of every burst.
- OFF:
  - Each strobe emits 0.
  - After OFF_SAMPLES samples, decrement the remaining-burst count. If it reaches 0, go to FINISH; otherwise go to ON.
- FINISH: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
- Between strobes: axiov=0 and axiod holds the last value. In IDLE, axiod=0.
- abort=1 in ON/OFF: IDLE next cycle, busy=0, axiov=0, axiod=0, no done pulse. abort has priority over a coincident strobe. abort in IDLE or FINISH is ignored.
- start while busy=1 is ignored and not queued. start in the FINISH cycle is ignored.
- Counter widths: $clog2(max(ON_SAMPLES,OFF_SAMPLES)+1) for sample counts; $clog2(CLKS_PER_SAMPLE) for the strobe counter. No wrap occurs within legal parameter ranges.
- Arithmetic is signed SAMPLE_DATA_WIDTH+1 internally, then saturated to the signed SAMPLE_DATA_WIDTH range.

Optional Feature:
- Macro: BURST_TONE_NOISE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on rst and on every accepted start) advances once per strobe.
  - Every sample gets {lfsr[1:0]} − 2 added (range −2..+1), saturated to the signed range. This applies to OFF samples too.
- Undefined: no LFSR logic is synthesized; samples are exact ±AMPLITUDE / 0.

Decomposition:
- Package burst_tone_pkg:
  - state enum (IDLE, ON, OFF, FINISH);
  - LFSR seed and tap constants;
  - saturate function.
- Sub-module sample_strobe_gen:
  - parameter CLKS_PER_SAMPLE;
  - ports clk, rst, clear, enable, strobe;
  - instantiated once.

Test Plan (CLKS_PER_SAMPLE=4, HALF_PERIOD_SAMPLES=2, ON_SAMPLES=8, OFF_SAMPLES=4, AMPLITUDE=100, noise off):
- Reset held 3 cycles, then released with start=0 → busy=0, done=0, axiov=0, axiod=0 indefinitely.
- start with num_bursts=1 → 12 strobes spaced 4 cycles, first in the cycle after edge k+4, carrying 100,100,−100,−100,100,100,−100,−100,0,0,0,0; then one done pulse with busy falling in the same cycle.
- start with num_bursts=0 → done pulse in the cycle after acceptance, no axiov, busy never 1.
- num_bursts=3, with start re-pulsed while busy → exactly 36 strobes (the 2nd start is ignored); each burst begins with +100; one done pulse.
- abort on the 5th ON strobe cycle, and separately rst mid-OFF → IDLE next cycle, no further axiov, no done; a new start then works normally.
- With BURST_TONE_NOISE_EN, num_bursts=1 → every sample is within [target−2, target+1]; the sequence is identical across two runs (seed reload).
